mem_io_ctrl: RTL

Sequencer for the board's 16-bit asynchronous external memory. It accepts single read and write requests from the front-panel logic and steps the chip-enable, output-enable, write-enable and data-bus-drive strobes through fixed phases. It returns read data and exports its one-hot state to the hexDisplay block, which shows progress ("rEAd_0", "rItE_3", ...) and the read result.

---
 rtl/mem_io_pkg.sv | 59 +++++
 rtl/mem_io_wait_timer.sv | 24 ++
 rtl/mem_io_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// Shared types for the external async-memory sequencer: one-hot state
// encoding (also consumed by hexDisplay) and the state-to-strobe decode.
package mem_io_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [11:0] {
    IDLE       = 12'h001,
    READ_ST0   = 12'h002,
    READ_ST1   = 12'h004,
    READ_ST2   = 12'h008,
    READ_WAIT  = 12'h010,
    READ_DONE  = 12'h020,
    WRITE_ST0  = 12'h040,
    WRITE_ST1  = 12'h080,
    WRITE_ST2  = 12'h100,
    WRITE_ST3  = 12'h200,
    WRITE_ST4  = 12'h400,
    WRITE_WAIT = 12'h800
  } io_statetype;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
    logic busy;
  } io_strobe_t;

  localparam io_strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                         dq_oe: 1'b0, busy: 1'b0};

  // Strobes depend only on the state they are registered alongside.
  function automatic io_strobe_t io_strobes(input io_statetype s);
    io_strobe_t st;
    st      = STROBE_IDLE;
    st.busy = (s != IDLE);
    case (s)
      READ_ST0:  st.ce_n = 1'b0;
      READ_ST1, READ_ST2, READ_WAIT: begin
        st.ce_n = 1'b0;
        st.oe_n = 1'b0;
      end
      WRITE_ST0: st.ce_n = 1'b0;
      WRITE_ST1, WRITE_ST4: begin
        st.ce_n  = 1'b0;
        st.dq_oe = 1'b1;
      end
      WRITE_ST2, WRITE_ST3: begin
        st.ce_n  = 1'b0;
        st.dq_oe = 1'b1;
        st.we_n  = 1'b0;
      end
      default: ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mem_io_wait_timer.sv
// Wait-state abort counter; counts cycles spent in a wait state and flags
// the last permitted one. Built only when MEM_IO_TIMEOUT_EN is defined.
module mem_io_wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  // Wait states are never adjacent, so dropping run_i restarts the count.
  always_comb cnt_d = run_i ? cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (cnt_q == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_io_ctrl.sv
// Single-request sequencer for the 16-bit async external memory.
// Optional wait-state timeout is enabled with `define MEM_IO_TIMEOUT_EN.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_ack,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_dq_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_out,
  output logic              mem_dq_oe,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output io_statetype       state,
  output logic              err
);

  io_statetype       state_q, state_d;
  io_strobe_t        strb_q, strb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef MEM_IO_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state_q == READ_WAIT) || (state_q == WRITE_WAIT);

  mem_io_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (in_wait),
    .expired_o(timeout)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = READ_ST0;
          addr_d  = addr;
          err_d   = 1'b0;
        end else if (wr_req) begin
          state_d = WRITE_ST0;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
        end
      end
      READ_ST0:  state_d = READ_ST1;
      READ_ST1:  state_d = READ_ST2;
      READ_ST2:  state_d = READ_WAIT;
      // mem_rdy wins over an expiring timer on the terminal cycle.
      READ_WAIT: begin
        if (mem_rdy) begin
          rdata_d = mem_dq_in;
          state_d = READ_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      READ_DONE: if (rd_ack) state_d = IDLE;
      WRITE_ST0: state_d = WRITE_ST1;
      WRITE_ST1: state_d = WRITE_ST2;
      WRITE_ST2: state_d = WRITE_ST3;
      WRITE_ST3: state_d = WRITE_ST4;
      WRITE_ST4: state_d = WRITE_WAIT;
      WRITE_WAIT: begin
        if (mem_rdy) begin
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered copies
  // always match the registered state without a combinational output path.
  assign strb_d = io_strobes(state_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      strb_q  <= STROBE_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign state      = state_q;
  assign mem_addr   = addr_q;
  assign mem_dq_out = wdata_q;
  assign mem_dq_oe  = strb_q.dq_oe;
  assign mem_ce_n   = strb_q.ce_n;
  assign mem_oe_n   = strb_q.oe_n;
  assign mem_we_n   = strb_q.we_n;
  assign busy       = strb_q.busy;
  assign rdata      = rdata_q;
  assign err        = err_q;

endmodule
